// File: rtl/step_dir_decoder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : step_dir_decoder_if
//  Description : Bundles the step/direction inputs and the host-side read
//                port of step_dir_decoder. The master is the pulse source /
//                host; the slave is the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface step_dir_decoder_if #(
  parameter int POS_W = 16
);
  logic             Pulse;
  logic             Dir;
  logic             CLR;
  logic             RD;
  logic [7:0]       D;
  logic [POS_W-1:0] Position;
  logic             Flag_T;
  logic             Flag_empty;
  logic             Flag_full;
  logic             Flag_ovf;

  modport master (
    output Pulse, Dir, CLR, RD,
    input  D, Position, Flag_T, Flag_empty, Flag_full, Flag_ovf
  );

  modport slave (
    input  Pulse, Dir, CLR, RD,
    output D, Position, Flag_T, Flag_empty, Flag_full, Flag_ovf
  );
endinterface
`default_nettype wire

// File: rtl/step_dir_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : step_dir_decoder
//  Description : Receive side of a step/direction link. Synchronises Pulse
//                and Dir, tracks absolute position, measures net steps per
//                WINDOW clocks as a sign-magnitude byte and queues those
//                samples in a 4-entry FIFO read by a rising-edge strobe.
//                Optional macro STEP_DIR_DECODER_POS_SAT_EN: Position
//                saturates at the signed limits instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_dir_decoder #(
  parameter int WINDOW = 1000,
  parameter int POS_W  = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  step_dir_decoder_if.slave  bus
);

  localparam int                 CNT_W   = $clog2(WINDOW);
  localparam logic [CNT_W-1:0]   TC_VAL  = CNT_W'(WINDOW - 1);
  localparam logic [2:0]         DEPTH   = 3'd4;
`ifdef STEP_DIR_DECODER_POS_SAT_EN
  localparam logic [POS_W-1:0]   POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0]   POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
`endif

  // Synchronisers; pulse_sync[2] is the delayed copy used for edge detection
  logic [2:0]       pulse_sync;
  logic [1:0]       dir_sync;
  logic             step;
  logic             step_dir;

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_next;

  logic [CNT_W-1:0] win_cnt;
  logic             tc;
  logic             t_flag;

  logic signed [8:0] net;
  logic signed [8:0] net_next;
  logic signed [9:0] net_sum;
  logic [8:0]        net_mag;
  logic [7:0]        sample;

  logic [7:0]       mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic [2:0]       count_next;
  logic             rd_prev;
  logic             pop_edge;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;
  logic [7:0]       d_out;
  logic             empty_flag;
  logic             full_flag;
  logic             ovf_flag;

  // Two-stage synchronisers for the asynchronous step/direction inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_sync <= 3'b000;
      dir_sync   <= 2'b00;
    end else begin
      pulse_sync <= {pulse_sync[1:0], bus.Pulse};
      dir_sync   <= {dir_sync[0], bus.Dir};
    end
  end

  assign step     = pulse_sync[1] & ~pulse_sync[2];
  assign step_dir = dir_sync[1];
  assign tc       = (win_cnt == TC_VAL);

  // Next position: CLR wins over a coincident step, which is lost for position
  always_comb begin
    pos_next = pos;
    if (bus.CLR) begin
      pos_next = '0;
    end else if (step) begin
`ifdef STEP_DIR_DECODER_POS_SAT_EN
      if (!step_dir && (pos != POS_MAX)) begin
        pos_next = pos + POS_W'(1);
      end else if (step_dir && (pos != POS_MIN)) begin
        pos_next = pos - POS_W'(1);
      end
`else
      pos_next = step_dir ? (pos - POS_W'(1)) : (pos + POS_W'(1));
`endif
    end
  end

  // Window accumulator update with +/-255 saturation and sample encoding
  always_comb begin
    net_sum = {net[8], net};
    if (step) begin
      net_sum = step_dir ? (net_sum - 10'sd1) : (net_sum + 10'sd1);
    end
    if (net_sum > 10'sd255) begin
      net_next = 9'sd255;
    end else if (net_sum < -10'sd255) begin
      net_next = -9'sd255;
    end else begin
      net_next = net_sum[8:0];
    end
    net_mag = net_next[8] ? 9'(-net_next) : 9'(net_next);
    sample  = {net_next[8], (net_mag > 9'd127) ? 7'h7F : net_mag[6:0]};
  end

  // FIFO control: pop on RD rising edge, push at window terminal count
  always_comb begin
    pop_edge   = bus.RD & ~rd_prev;
    pop_ok     = pop_edge && (count != 3'd0);
    push_ok    = tc && ((count != DEPTH) || pop_ok);
    drop       = tc && (count == DEPTH) && !pop_ok;
    count_next = count + {2'b00, push_ok} - {2'b00, pop_ok};
  end

  // Position, window counter, accumulator and window toggle flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos     <= '0;
      win_cnt <= '0;
      net     <= '0;
      t_flag  <= 1'b0;
    end else begin
      pos <= pos_next;
      if (tc) begin
        // A step on the TC cycle is already folded into the closing sample
        win_cnt <= '0;
        net     <= '0;
        t_flag  <= ~t_flag;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
        net     <= net_next;
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= sample;
    end
  end

  // FIFO pointers, read data, registered status flags and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      rd_prev    <= 1'b0;
      d_out      <= 8'h00;
      empty_flag <= 1'b1;
      full_flag  <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      rd_prev <= bus.RD;
      count   <= count_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (pop_edge) begin
        d_out <= pop_ok ? mem[rd_ptr] : 8'h00;
      end
      empty_flag <= (count_next == 3'd0);
      full_flag  <= (count_next == DEPTH);
      // A drop in the same cycle as CLR is still reported
      if (drop) begin
        ovf_flag <= 1'b1;
      end else if (bus.CLR) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  assign bus.D          = d_out;
  assign bus.Position   = pos;
  assign bus.Flag_T     = t_flag;
  assign bus.Flag_empty = empty_flag;
  assign bus.Flag_full  = full_flag;
  assign bus.Flag_ovf   = ovf_flag;

endmodule
`default_nettype wire

// File: tb/tb_step_dir_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_step_dir_decoder
//  Description : Directed self-checking bench for step_dir_decoder. A second
//                8-bit-position instance exercises the position wrap/limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_dir_decoder;

  localparam int WINDOW = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  step_dir_decoder_if #(.POS_W(16)) sd ();
  step_dir_decoder_if #(.POS_W(8))  sd8 ();

  step_dir_decoder #(.WINDOW(WINDOW), .POS_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sd.slave)
  );

  step_dir_decoder #(.WINDOW(WINDOW), .POS_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sd8.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses reach both instances; Dir is set up 3 clocks ahead of the first rise
  task automatic send_pulses(input int n, input logic dir);
    sd.Dir  = dir;
    sd8.Dir = dir;
    tick(3);
    for (int i = 0; i < n; i++) begin
      sd.Pulse  = 1'b1;
      sd8.Pulse = 1'b1;
      tick(2);
      sd.Pulse  = 1'b0;
      sd8.Pulse = 1'b0;
      tick(2);
    end
    tick(2);
  endtask

  task automatic wait_window();
    logic old;
    bit   seen;
    old  = sd.Flag_T;
    seen = 1'b0;
    for (int i = 0; i < WINDOW + 10; i++) begin
      @(negedge clk);
      if (sd.Flag_T !== old) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL window_timeout: Flag_T got no toggle, expected a toggle within %0d clk", WINDOW + 10);
    end
  endtask

  task automatic read_fifo(output logic [7:0] d);
    sd.RD = 1'b1;
    tick(1);
    sd.RD = 1'b0;
    d = sd.D;
    tick(1);
  endtask

  task automatic drain();
    logic [7:0] tmp;
    for (int i = 0; i < 6; i++) begin
      if (sd.Flag_empty === 1'b1) break;
      read_fifo(tmp);
    end
  endtask

  task automatic do_clr();
    sd.CLR = 1'b1;
    tick(1);
    sd.CLR = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int         edge_no;
    sd.Pulse = 0; sd.Dir = 0; sd.CLR = 0; sd.RD = 0;
    sd8.Pulse = 0; sd8.Dir = 0; sd8.CLR = 0; sd8.RD = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    send_pulses(3, 1'b0);
    n_checks++;
    if (sd.Position !== 16'd3) begin
      n_fail++; $display("FAIL pre_reset_pos: got %0h expected 0003", sd.Position);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sd.Position !== 16'd0) begin
      n_fail++; $display("FAIL reset_pos: got %0h expected 0000", sd.Position);
    end
    n_checks++;
    if (sd8.Position !== 8'd0) begin
      n_fail++; $display("FAIL reset_pos8: got %0h expected 00", sd8.Position);
    end
    n_checks++;
    if (sd.D !== 8'h00) begin
      n_fail++; $display("FAIL reset_D: got %0h expected 00", sd.D);
    end
    n_checks++;
    if (sd.Flag_T !== 1'b0) begin
      n_fail++; $display("FAIL reset_T: got %0b expected 0", sd.Flag_T);
    end
    n_checks++;
    if (sd.Flag_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_empty: got %0b expected 1", sd.Flag_empty);
    end
    n_checks++;
    if (sd.Flag_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got %0b expected 0", sd.Flag_full);
    end
    n_checks++;
    if (sd.Flag_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %0b expected 0", sd.Flag_ovf);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
    for (int i = 1; i <= WINDOW + 5; i++) begin
      @(posedge clk);
      #1;
      if (sd.Flag_T === 1'b1) begin
        edge_no = i;
        break;
      end
    end
    n_checks++;
    if (edge_no != WINDOW) begin
      n_fail++; $display("FAIL first_window_edge: got %0d expected %0d", edge_no, WINDOW);
    end
    n_checks++;
    if (sd.Flag_empty !== 1'b0) begin
      n_fail++; $display("FAIL first_push_empty: got %0b expected 0", sd.Flag_empty);
    end
    @(negedge clk);
    read_fifo(d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++; $display("FAIL first_sample: got %0h expected 00", d);
    end
    n_checks++;
    if (sd.Flag_empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_after_read: got %0b expected 1", sd.Flag_empty);
    end
  endtask

  task automatic test_forward();
    logic [7:0] d;
    logic       t0;
    wait_window();
    drain();
    send_pulses(37, 1'b0);
    n_checks++;
    if (sd.Position !== 16'd37) begin
      n_fail++; $display("FAIL fwd_pos: got %0h expected 0025", sd.Position);
    end
    t0 = sd.Flag_T;
    wait_window();
    n_checks++;
    if (sd.Flag_T !== ~t0) begin
      n_fail++; $display("FAIL fwd_T: got %0b expected %0b", sd.Flag_T, ~t0);
    end
    read_fifo(d);
    n_checks++;
    if (d !== 8'h25) begin
      n_fail++; $display("FAIL fwd_D: got %0h expected 25", d);
    end
  endtask

  task automatic test_reverse();
    logic [7:0] d;
    wait_window();
    drain();
    do_clr();
    n_checks++;
    if (sd.Position !== 16'd0) begin
      n_fail++; $display("FAIL clr_pos: got %0h expected 0000", sd.Position);
    end
    send_pulses(200, 1'b1);
    n_checks++;
    if (sd.Position !== 16'hFF38) begin
      n_fail++; $display("FAIL rev_pos: got %0h expected ff38", sd.Position);
    end
    wait_window();
    read_fifo(d);
    n_checks++;
    if (d !== 8'hFF) begin
      n_fail++; $display("FAIL rev_sat_D: got %0h expected ff", d);
    end
  endtask

  task automatic test_mixed();
    logic [7:0] d;
    logic       t0;
    int         b;
    wait_window();
    b = cyc;
    drain();
    do_clr();
    send_pulses(10, 1'b0);
    send_pulses(14, 1'b1);
    // The 15th reverse step is timed so its detection lands on the TC cycle
    while (cyc < b + WINDOW - 3) @(negedge clk);
    t0 = sd.Flag_T;
    sd.Pulse  = 1'b1;
    sd8.Pulse = 1'b1;
    tick(2);
    sd.Pulse  = 1'b0;
    sd8.Pulse = 1'b0;
    tick(1);
    n_checks++;
    if (sd.Flag_T !== ~t0) begin
      n_fail++; $display("FAIL tc_toggle: got %0b expected %0b", sd.Flag_T, ~t0);
    end
    n_checks++;
    if (sd.Position !== 16'hFFFB) begin
      n_fail++; $display("FAIL mixed_pos: got %0h expected fffb", sd.Position);
    end
    read_fifo(d);
    n_checks++;
    if (d !== 8'h85) begin
      n_fail++; $display("FAIL mixed_D: got %0h expected 85", d);
    end
    wait_window();
    read_fifo(d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++; $display("FAIL after_tc_D: got %0h expected 00", d);
    end
  endtask

  task automatic test_fifo();
    logic [7:0] d;
    wait_window();
    drain();
    for (int w = 1; w <= 5; w++) begin
      send_pulses(w, 1'b0);
      wait_window();
      if (w == 4) begin
        n_checks++;
        if (sd.Flag_full !== 1'b1) begin
          n_fail++; $display("FAIL full_after_4: got %0b expected 1", sd.Flag_full);
        end
        n_checks++;
        if (sd.Flag_ovf !== 1'b0) begin
          n_fail++; $display("FAIL ovf_after_4: got %0b expected 0", sd.Flag_ovf);
        end
      end
    end
    n_checks++;
    if (sd.Flag_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after_5: got %0b expected 1", sd.Flag_ovf);
    end
    for (int r = 1; r <= 4; r++) begin
      read_fifo(d);
      n_checks++;
      if (d !== 8'(r)) begin
        n_fail++; $display("FAIL fifo_order_%0d: got %0h expected %0h", r, d, 8'(r));
      end
    end
    n_checks++;
    if (sd.Flag_empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_after_4_reads: got %0b expected 1", sd.Flag_empty);
    end
    read_fifo(d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++; $display("FAIL read_empty_D: got %0h expected 00", d);
    end
    n_checks++;
    if (sd.Position !== 16'd10) begin
      n_fail++; $display("FAIL pos_before_clr: got %0h expected 000a", sd.Position);
    end
    do_clr();
    n_checks++;
    if (sd.Position !== 16'd0) begin
      n_fail++; $display("FAIL clr_pos2: got %0h expected 0000", sd.Position);
    end
    n_checks++;
    if (sd.Flag_ovf !== 1'b0) begin
      n_fail++; $display("FAIL clr_ovf: got %0b expected 0", sd.Flag_ovf);
    end
    n_checks++;
    if (sd.Flag_empty !== 1'b1) begin
      n_fail++; $display("FAIL clr_keeps_fifo: got %0b expected 1", sd.Flag_empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_over;
    logic [7:0] exp_back;
`ifdef STEP_DIR_DECODER_POS_SAT_EN
    exp_over = 8'h7F;
    exp_back = 8'h7E;
`else
    exp_over = 8'h80;
    exp_back = 8'h7F;
`endif
    sd8.CLR = 1'b1;
    tick(1);
    sd8.CLR = 1'b0;
    send_pulses(127, 1'b0);
    n_checks++;
    if (sd8.Position !== 8'h7F) begin
      n_fail++; $display("FAIL wrap_preload: got %0h expected 7f", sd8.Position);
    end
    send_pulses(1, 1'b0);
    n_checks++;
    if (sd8.Position !== exp_over) begin
      n_fail++; $display("FAIL wrap_over: got %0h expected %0h", sd8.Position, exp_over);
    end
    send_pulses(1, 1'b1);
    n_checks++;
    if (sd8.Position !== exp_back) begin
      n_fail++; $display("FAIL wrap_back: got %0h expected %0h", sd8.Position, exp_back);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_mixed();
    test_fifo();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_dir_decoder.md
Name: step_dir_decoder

Overview:
- Receive end of the step/direction interface; consumes the `Pulse`/`Dir` pair produced by the DDA pulse generator.
- Tracks absolute position and measures net pulses per fixed sample window.
- Encodes each window as a sign-magnitude byte in the same format as the generator's commands: bit7 = direction, bits[6:0] = count.
- Queues measurements in a 4-entry FIFO for a host to read via an edge-triggered strobe. Used for loopback verification and closed-loop feedback.

Parameters:
- WINDOW, 1000: clk cycles per measurement window (>= 2).
- POS_W, 16: position counter width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- Pulse  input  1  step pulse, asynchronous to clk; each rising edge = one step
- Dir  input  1  direction; 0 = forward (+1), 1 = reverse (-1)
- CLR  input  1  synchronous clear of position and overflow flag
- RD  input  1  FIFO read strobe; rising edge pops one entry
- D  output  8  last popped measurement, sign-magnitude
- Position  output  POS_W  signed two's-complement step position
- Flag_T  output  1  toggles at every window boundary
- Flag_empty  output  1  FIFO holds 0 entries
- Flag_full  output  1  FIFO holds 4 entries
- Flag_ovf  output  1  sticky; a measurement was dropped because the FIFO was full

Behaviour:
- Reset (rst_n = 0, asynchronous) clears all state and outputs:
  - D = 0, Position = 0, Flag_T = 0, Flag_empty = 1, Flag_full = 0, Flag_ovf = 0.
  - Window counter, window accumulator, FIFO pointers and synchronisers = 0.
  - The previous-RD register resets to 0.
- Input synchronisation: `Pulse` and `Dir` each pass through a 2-FF synchroniser. A step event is detected when the synced `Pulse` goes 0 -> 1.
  - `Dir` is taken from its synced value on the detect cycle.
  - `Position` updates on the 3rd clk edge after `Pulse` rises (Dir set up >= 3 clk earlier).
- Position: +1 if Dir = 0, -1 if Dir = 1. It wraps modulo 2^POS_W.
- Window:
  - The counter runs 0..WINDOW-1. At terminal count (TC) it returns to 0 and `Flag_T` toggles.
  - A 9-bit signed accumulator `net` adds ±1 per step event.
  - A step event on the TC cycle is included in the closing window.
  - At TC the sample is formed as bit7 = (net < 0) and bits[6:0] = min(|net|, 127) (saturating). Net = 0 gives 0x00.
  - `net` clears to 0 at TC, or loads ±1 if that step belonged to the next window; the TC-cycle step belongs to the closing window, so `net` loads 0.
  - The accumulator saturates at ±255 internally.
- FIFO: 4 entries, first in first out.
  - Push happens at TC.
  - Pop happens on an RD rising edge, detected via a registered previous RD. `D` loads the head entry on the following clk edge.
  - Pop while empty: D = 0 and pointers unchanged.
  - Push while full with no pop: the sample is dropped and `Flag_ovf` is set.
  - Push and pop in the same cycle while full: both proceed, count stays 4, no overflow.
  - Push and pop in the same cycle while empty: the pop returns D = 0 and the push is stored.
  - Flags are registered and valid the cycle after the count changes.
- CLR (synchronous, level): Position = 0 and Flag_ovf = 0.
  - FIFO, window counter and `net` are unaffected.
  - A step event in the same cycle as CLR is discarded for position but still counted in `net`.
- rst_n asserted mid-window: the partial window is discarded and no sample is pushed.

Optional Feature:
- Macro: STEP_DIR_DECODER_POS_SAT_EN.
- Defined: `Position` saturates at +(2^(POS_W-1)-1) and -(2^(POS_W-1)) instead of wrapping. Steps beyond a limit are ignored until a step in the opposite direction arrives.
- Undefined: modulo wrap as specified above.

Test Plan:
- Reset: hold rst_n = 0 mid-stream -> all outputs at reset values immediately (asynchronous); after release the first window closes at clk WINDOW, pushing 0x00 if no steps.
- Forward count: 37 pulses with Dir = 0 inside one window -> Position = 37, Flag_T toggles, RD edge gives D = 0x25.
- Reverse and saturation: 200 pulses with Dir = 1 in one window (WINDOW = 1000, pulse every 4 clk) -> Position = -200 (0xFF38), D = 0xFF (sign = 1, magnitude 127).
- Mixed direction: 10 forward then 15 reverse in one window -> D = 0x85 and Position = -5. A pulse on the TC cycle is counted in the closing window.
- FIFO boundaries: 5 windows with no reads -> Flag_full = 1 after the 4th, Flag_ovf = 1 after the 5th; 4 reads return the 4 oldest samples in order, then Flag_empty = 1; a 5th read gives D = 0; CLR clears Flag_ovf and Position only.
- Wrap: preload 32767 steps forward, then 1 more -> Position = 0x8000 (macro undefined) or stays 0x7FFF (STEP_DIR_DECODER_POS_SAT_EN defined).
